// File: rtl/pmu_wake_ctrl.sv
// pmu_wake_ctrl
//   Power-management sequencer. Walks the SoC through ACTIVE -> ENTERING ->
//   SLEEP -> WAKING -> ACTIVE. It has NUM_WAKE maskable sticky wake sources,
//   a peripheral idle handshake, abort of sleep entry, and a programmable
//   wake-settle delay.
//
// Ports
//   clk, rst       system clock, asynchronous active-high reset
//   addr, wdata    register bus byte address / write data
//   we, re         single-cycle write / read strobes
//   rdata          registered read data (holds between reads)
//   wake_src       level wake requests, synchronous to clk
//   idle_ack       peripherals report quiesced
//   idle_req       request to peripherals to quiesce
//   sleep_mode     high in SLEEP and WAKING
//   irq            |(pend & mask), registered
//
// Register map
//   0x0 CTRL     W: bit0 sleep request, bit3 W1C abort
//                R: bit0 sleep_mode, bits[2:1] state, bit3 abort
//   0x4 MASK     wake enables
//   0x8 PEND     sticky pending, W1C
//   0xC WAKE_DLY wake-settle cycles minus one
//
// State     | meaning
// ----------+--------------------------------------------------
// ACTIVE    | running normally, sleep requests accepted
// ENTERING  | idle_req raised, waiting for idle_ack (no timeout)
// SLEEP     | asleep, waiting for an enabled pending wake
// WAKING    | settle counter running down to zero

module pmu_wake_ctrl #(
  parameter int          NUM_WAKE     = 4,
  parameter int          CNT_W        = 16,
  parameter int unsigned WAKE_DLY_RST = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  input  logic                we,
  input  logic                re,
  input  logic [NUM_WAKE-1:0] wake_src,
  input  logic                idle_ack,
  output logic                idle_req,
  output logic                sleep_mode,
  output logic                irq
);

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_ENTERING = 2'd1,
    ST_SLEEP    = 2'd2,
    ST_WAKING   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_WAKE-1:0] mask_q, mask_d;
  logic [NUM_WAKE-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]    dly_q, dly_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic                idle_req_q, idle_req_d;
  logic                sleep_mode_q, sleep_mode_d;
  logic                irq_q, irq_d;
  logic [31:0]         rdata_q, rdata_d;

  logic        wr_ctrl, wr_mask, wr_pend, wr_dly;
  logic        wk;
  logic        abort_set;
  logic [31:0] rd_val;

  // Full wdata word is part of the bus; only the low bits land in registers.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

  assign wr_ctrl = we && (addr == 4'h0);
  assign wr_mask = we && (addr == 4'h4);
  assign wr_pend = we && (addr == 4'h8);
  assign wr_dly  = we && (addr == 4'hC);

  // Wake decision uses registered pend/mask, so a wake_src pulse moves the
  // FSM two cycles later.
  assign wk = |(pend_q & mask_q);

  // Read mux samples current (pre-write) register values.
  always_comb begin
    rd_val = 32'd0;
    case (addr)
      4'h0:    rd_val = {28'd0, abort_q, state_q, sleep_mode_q};
      4'h4:    rd_val = 32'(mask_q);
      4'h8:    rd_val = 32'(pend_q);
      4'hC:    rd_val = 32'(dly_q);
      default: rd_val = 32'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    pend_d    = pend_q;
    dly_d     = dly_q;
    cnt_d     = cnt_q;
    abort_set = 1'b0;
    rdata_d   = re ? rd_val : rdata_q;

    if (wr_mask) mask_d = wdata[NUM_WAKE-1:0];
    if (wr_dly)  dly_d  = wdata[CNT_W-1:0];

    // A new wake request beats a simultaneous W1C of the same bit.
    if (wr_pend) pend_d = pend_q & ~wdata[NUM_WAKE-1:0];
    pend_d = pend_d | wake_src;

    case (state_q)
      ST_ACTIVE: begin
        if (wr_ctrl && wdata[0]) begin
          if (wk) abort_set = 1'b1;
          else    state_d   = ST_ENTERING;
        end
      end
      ST_ENTERING: begin
        // A pending wake outranks idle_ack: entry is abandoned.
        if (wk) begin
          state_d   = ST_ACTIVE;
          abort_set = 1'b1;
        end else if (idle_ack) begin
          state_d = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (wk) begin
          state_d = ST_WAKING;
          cnt_d   = dly_q;
        end
      end
      ST_WAKING: begin
        // Counter was loaded on entry; later WAKE_DLY writes do not touch it.
        if (cnt_q == '0) state_d = ST_ACTIVE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_ACTIVE;
    endcase

    abort_d = abort_q;
    if (wr_ctrl && wdata[3]) abort_d = 1'b0;
    if (abort_set)           abort_d = 1'b1;

    // Outputs registered from next-state values so they line up with state_q.
    idle_req_d   = (state_d != ST_ACTIVE);
    sleep_mode_d = (state_d == ST_SLEEP) || (state_d == ST_WAKING);
    irq_d        = |(pend_d & mask_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ACTIVE;
      mask_q       <= '1;
      pend_q       <= '0;
      dly_q        <= CNT_W'(WAKE_DLY_RST);
      cnt_q        <= '0;
      abort_q      <= 1'b0;
      idle_req_q   <= 1'b0;
      sleep_mode_q <= 1'b0;
      irq_q        <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      pend_q       <= pend_d;
      dly_q        <= dly_d;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
      idle_req_q   <= idle_req_d;
      sleep_mode_q <= sleep_mode_d;
      irq_q        <= irq_d;
      rdata_q      <= rdata_d;
    end
  end

  assign rdata      = rdata_q;
  assign idle_req   = idle_req_q;
  assign sleep_mode = sleep_mode_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_pmu_wake_ctrl.sv
module tb_pmu_wake_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [3:0]  wake_src = 4'h0;
  logic        idle_ack = 1'b0;
  logic        idle_req;
  logic        sleep_mode;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  pmu_wake_ctrl #(.NUM_WAKE(4), .CNT_W(16), .WAKE_DLY_RST(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .rdata(rdata),
    .we(we), .re(re), .wake_src(wake_src), .idle_ack(idle_ack),
    .idle_req(idle_req), .sleep_mode(sleep_mode), .irq(irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Phase: 0 ACTIVE, 1 ENTERING, 2 SLEEP, 3 WAKING (CTRL read encoding).
  logic [1:0]  m_state;
  logic [3:0]  m_pend, m_mask;
  logic [15:0] m_dly;
  logic        m_abort;
  logic [31:0] m_rdata;
  int          m_left;  // WAKING cycles still to spend

  task automatic model_reset();
    m_state = 2'd0; m_pend = 4'h0; m_mask = 4'hF; m_dly = 16'd8;
    m_abort = 1'b0; m_rdata = 32'd0; m_left = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'h0:    return {28'd0, m_abort, m_state, m_state[1]};
      4'h4:    return {28'd0, m_mask};
      4'h8:    return {28'd0, m_pend};
      4'hC:    return {16'd0, m_dly};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    bit wake_ok = (m_pend & m_mask) != 4'h0;
    bit ctrl_wr = we && addr == 4'h0;
    bit refuse  = 1'b0;
    if (re) m_rdata = model_read(addr);
    case (m_state)
      2'd0: if (ctrl_wr && wdata[0]) begin
              if (wake_ok) refuse = 1'b1; else m_state = 2'd1;
            end
      2'd1: if (wake_ok) begin m_state = 2'd0; refuse = 1'b1; end
            else if (idle_ack) m_state = 2'd2;
      2'd2: if (wake_ok) begin m_state = 2'd3; m_left = int'(m_dly) + 1; end
      default: begin
        m_left = m_left - 1;
        if (m_left == 0) m_state = 2'd0;
      end
    endcase
    if (ctrl_wr && wdata[3]) m_abort = 1'b0;
    if (refuse) m_abort = 1'b1;
    if (we && addr == 4'h8) m_pend = m_pend & ~wdata[3:0];
    m_pend = m_pend | wake_src;
    if (we && addr == 4'h4) m_mask = wdata[3:0];
    if (we && addr == 4'hC) m_dly = wdata[15:0];
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    chk("model_rdata", rdata, m_rdata);
    chk("model_sleep", 32'(sleep_mode), 32'(m_state[1]));
    chk("model_idle", 32'(idle_req), 32'(m_state != 2'd0));
    chk("model_irq", 32'(irq), 32'((m_pend & m_mask) != 4'h0));
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0; wdata = 32'd0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    re = 1'b1; addr = a;
    tick();
    re = 1'b0;
    v = rdata;
  endtask

  typedef struct {
    logic        we, re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  ws;
    logic        ack;
    logic [31:0] e_rd;
    logic        e_sl, e_id, e_irq;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic r, input logic [3:0] a,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] erd, input logic esl,
                              input logic eid, input logic eirq);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.wdata = d; v.ws = s; v.ack = 1'b1;
    v.e_rd = erd; v.e_sl = esl; v.e_id = eid; v.e_irq = eirq;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    logic [31:0] v;
    int n;

    // Reset values, checked while rst is still held.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_sleep", 32'(sleep_mode), 32'd0);
    chk("rst_idle", 32'(idle_req), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;

    // Table: reset reads, sleep entry with idle_ack tied high, wake with
    // the default 8-cycle delay (WAKING lasts 9 cycles), then PEND W1C.
    vt.push_back(mk(0, 1, 4'h4, 0, 0, 32'hF, 0, 0, 0));
    vt.push_back(mk(0, 1, 4'h8, 0, 0, 32'h0, 0, 0, 0));
    vt.push_back(mk(0, 1, 4'hC, 0, 0, 32'h8, 0, 0, 0));
    vt.push_back(mk(0, 1, 4'h0, 0, 0, 32'h0, 0, 0, 0));
    vt.push_back(mk(1, 0, 4'h0, 1, 0, 32'h0, 0, 1, 0));  // ENTERING
    vt.push_back(mk(0, 0, 4'h0, 0, 0, 32'h0, 1, 1, 0));  // SLEEP
    vt.push_back(mk(0, 1, 4'h0, 0, 0, 32'h5, 1, 1, 0));  // CTRL=0x5
    vt.push_back(mk(0, 0, 4'h0, 0, 4'h4, 32'h5, 1, 1, 1)); // pend[2]
    vt.push_back(mk(0, 0, 4'h0, 0, 0, 32'h5, 1, 1, 1));  // WAKING entry
    for (int i = 0; i < 8; i++) vt.push_back(mk(0, 0, 4'h0, 0, 0, 32'h5, 1, 1, 1));
    vt.push_back(mk(0, 0, 4'h0, 0, 0, 32'h5, 0, 0, 1));  // 9th cycle: ACTIVE
    vt.push_back(mk(0, 1, 4'h8, 0, 0, 32'h4, 0, 0, 1));
    vt.push_back(mk(1, 0, 4'h8, 4, 0, 32'h4, 0, 0, 0));
    vt.push_back(mk(0, 1, 4'h8, 0, 0, 32'h0, 0, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      we = vt[i].we; re = vt[i].re; addr = vt[i].addr; wdata = vt[i].wdata;
      wake_src = vt[i].ws; idle_ack = vt[i].ack;
      tick();
      chk($sformatf("vec%0d_rdata", i), rdata, vt[i].e_rd);
      chk($sformatf("vec%0d_sleep", i), 32'(sleep_mode), 32'(vt[i].e_sl));
      chk($sformatf("vec%0d_idle", i), 32'(idle_req), 32'(vt[i].e_id));
      chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vt[i].e_irq));
    end
    we = 0; re = 0; wdata = 0; wake_src = 0;

    // Masked source pends but does not wake; unmasked one does.
    wr(4'h4, 32'h1);
    idle_ack = 1'b1;
    wr(4'h0, 32'h1);
    tick();
    chk("mask_in_sleep", 32'(sleep_mode), 32'd1);
    wake_src = 4'h8; tick(); wake_src = 4'h0;
    tick(); tick();
    rd(4'h8, v);
    chk("mask_pend", v, 32'h8);
    chk("mask_irq", 32'(irq), 32'd0);
    chk("mask_still_sleep", 32'(sleep_mode), 32'd1);
    wake_src = 4'h1; tick(); wake_src = 4'h0;
    n = 0;
    while (sleep_mode && n < 40) begin tick(); n++; end
    chk("mask_woke", 32'(sleep_mode), 32'd0);
    chk("wake_len", 32'(n), 32'd10);
    wr(4'h8, 32'hF);
    wr(4'h4, 32'hF);

    // Entry abort while waiting for idle_ack.
    idle_ack = 1'b0;
    wr(4'h0, 32'h1);
    chk("ent_idle_req", 32'(idle_req), 32'd1);
    wake_src = 4'h2; tick(); wake_src = 4'h0;
    tick();
    chk("ent_abort_idle", 32'(idle_req), 32'd0);
    rd(4'h0, v);
    chk("ent_abort_flag", v, 32'h8);
    wr(4'h0, 32'h8);
    rd(4'h0, v);
    chk("abort_w1c", v, 32'h0);
    wr(4'h8, 32'hF);

    // Refused request with a pending wake; W1C vs set collision.
    wake_src = 4'h1; tick(); wake_src = 4'h0;
    wr(4'h0, 32'h1);
    chk("refuse_idle", 32'(idle_req), 32'd0);
    rd(4'h0, v);
    chk("refuse_ctrl", v, 32'h8);
    we = 1'b1; addr = 4'h8; wdata = 32'h1; wake_src = 4'h1;
    tick();
    we = 1'b0; wdata = 0; wake_src = 4'h0;
    rd(4'h8, v);
    chk("set_beats_clr", v, 32'h1);
    wr(4'h8, 32'h1);
    rd(4'h8, v);
    chk("pend_cleared", v, 32'h0);
    wr(4'h0, 32'h8);

    // WAKE_DLY=0: exactly one WAKING cycle.
    wr(4'hC, 32'h0);
    idle_ack = 1'b1;
    wr(4'h0, 32'h1);
    tick();
    chk("dly0_sleep", 32'(sleep_mode), 32'd1);
    wake_src = 4'h1; tick(); wake_src = 4'h0;
    tick();
    chk("dly0_waking", 32'(sleep_mode), 32'd1);
    rd(4'h0, v);
    chk("dly0_ctrl_waking", v, 32'h7);
    chk("dly0_done", 32'(sleep_mode), 32'd0);
    wr(4'h8, 32'hF);
    wr(4'hC, 32'h8);

    // Asynchronous reset from SLEEP.
    wr(4'h4, 32'h3);
    wr(4'hC, 32'h3);
    wr(4'h0, 32'h1);
    tick();
    chk("ar_sleep", 32'(sleep_mode), 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("ar_sleep_drop", 32'(sleep_mode), 32'd0);
    chk("ar_idle_drop", 32'(idle_req), 32'd0);
    chk("ar_rdata", rdata, 32'd0);
    tick();
    rst = 1'b0;
    rd(4'h4, v); chk("ar_mask", v, 32'hF);
    rd(4'h8, v); chk("ar_pend", v, 32'h0);
    rd(4'hC, v); chk("ar_dly", v, 32'h8);
    rd(4'h0, v); chk("ar_ctrl", v, 32'h0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] sel;
      we = ($urandom_range(0, 9) < 3);
      re = ($urandom_range(0, 9) < 3);
      sel = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : {sel, 2'b00};
      wdata = $urandom;
      if (addr == 4'hC) wdata = $urandom_range(0, 6);
      wake_src = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
      idle_ack = $urandom_range(0, 1) != 0;
      tick();
    end
    we = 0; re = 0; wake_src = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
